mem_io_responder: RTL
=====================

# mem_io_responder

Responder end of the CPU byte-wide memory bus: accepts address/write/data from the CPU core and returns read data one cycle later. Decodes a 128 KB byte RAM plus the memory-mapped I/O page at 0x30000: console input, console output, cycle counter and program-stop. Sits between the CPU top and the board-level RAM/UART glue, and serves as the simulation memory model for the core.

## Interface
Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
- FIFO_DEPTH_LOG2, 4, log2 depth of both rx and tx byte FIFOs

Ports (clock and reset first):
- clk_in  input  1  system clock; one clock domain
- rst_in  input  1  asynchronous, active-high reset
- rdy_in  input  1  bus qualifier; when low, no state changes except counter hold
- cpu_a  input  32  byte address; only [17:0] decoded
- cpu_wr  input  1  1 = write, 0 = read
- cpu_wdata  input  8  write data from CPU
- cpu_rdata  output  8  registered read data to CPU
- rx_data  input  8  host input byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  rx FIFO not full
- tx_data  output  8  console output byte (head of tx FIFO)
- tx_valid  output  1  tx FIFO not empty
- tx_ready  input  1  downstream accepts tx_data
- tx_overflow  output  1  sticky: a tx byte was dropped
- prog_stop  output  1  sticky: program-stop write seen

## Operation
- Decode: cpu_a[17:16]==2'b11 selects I/O; otherwise RAM at cpu_a[RAM_ADDR_W-1:0].
- RAM read: byte at address. RAM write: byte stored at end of the cycle.
- I/O read 0x30000: pops rx FIFO head; returns 0x00 when empty, with no pop.
- I/O write 0x30000: pushes to tx FIFO. Writing 0x00 is ignored. Push while full drops the byte and sets tx_overflow.
- I/O read 0x30004: latches 32-bit cycle counter into snapshot and returns snapshot[7:0] (new value). Reads of 0x30005/6/7 return snapshot bytes 1/2/3 without relatching.
- I/O write 0x30004: sets prog_stop, freezes the counter and pushes 0x00 into the tx FIFO (bypasses the zero filter; dropped if full).
- Other I/O offsets: reads return 0x00; writes are ignored.
- Cycle counter: 32-bit, increments every clk_in with rdy_in high and prog_stop low. Wraps 0xFFFFFFFF -> 0.
- rx side: push when rx_valid && rx_ready. tx side: pop when tx_valid && tx_ready. Both are independent of rdy_in.
- rdy_in low: no RAM write, no CPU-side FIFO push/pop, cpu_rdata holds, counter holds.

## Timing
- Read latency 1: address presented in cycle N gives cpu_rdata valid in cycle N+1 and held until the next qualified read.
- Writes take effect at the clock edge ending cycle N; a read of the same address in N+1 returns new data.
- During a CPU write cycle, cpu_rdata holds its previous value.
- FIFO full/empty are evaluated before the edge. A CPU pop of an empty rx FIFO in the same cycle as an external push returns 0x00; the pushed byte remains. A push to a full tx FIFO is dropped even if tx pops in the same cycle.
- rx_ready and tx_valid are registered-state derived, with no combinational path from the CPU bus.
- Reset (async, any time, including mid-access): cpu_rdata=0, rx_ready=1, tx_valid=0, tx_data=0, tx_overflow=0, prog_stop=0, counter=0, snapshot=0, both FIFOs empty. RAM contents are not cleared.

## Configuration
- MEMIO_CYCLE_CNT_EN defined: counter, snapshot and the 0x30004..0x30007 read behaviour are present as above.
- Undefined: counter and snapshot registers are absent, and reads of 0x30004..0x30007 return 0x00. Write 0x30004 (prog_stop + 0x00 push) is unchanged.

## Structure
- Shared package/header: IO_BASE (2'b11 at [17:16]), IO_OFS_CONSOLE (3'd0), IO_OFS_CLOCK (3'd4), byte and address width constants.
- One sub-module: byte_fifo (synchronous FIFO, parameter FIFO_DEPTH_LOG2, async active-high reset, push/pop/full/empty/dout), instantiated twice (rx, tx).
- RAM is an inferred array inside the top, with a registered read port.

## Test plan
- Write 0xA5 to 0x00123, then read 0x00123 next cycle -> cpu_rdata=0xA5 one cycle after the read address.
- Push rx bytes 0x41, 0x42; read 0x30000 three times -> 0x41, 0x42, 0x00. rx_ready stays 1.
- Write 0x00, 0x48, 0x49 to 0x30000 with tx_ready=0 -> tx holds 0x48, 0x49 only. Fill to 16 and write one more -> tx_overflow=1 and the 17th byte is absent.
- With MEMIO_CYCLE_CNT_EN, after 100 qualified cycles read 0x30004..0x30007 -> little-endian snapshot taken at the 0x30004 read, unchanged across bytes 1–3.
- Write 0x30004 -> prog_stop=1 next cycle, counter frozen, 0x00 appears on tx_data.
- Assert rst_in mid-read and mid-write with rdy_in toggling -> all outputs at reset values immediately. RAM byte previously written survives reset.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU byte-bus responder.
// Address map: RAM below 0x30000, I/O page at 0x30000.
package mem_io_responder_pkg;
   localparam int BYTE_W     = 8;
   localparam int CPU_ADDR_W = 32;
   localparam logic [1:0] IO_BASE        = 2'b11;
   localparam logic [2:0] IO_OFS_CONSOLE = 3'd0;
   localparam logic [2:0] IO_OFS_CLOCK   = 3'd4;
   typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus console rx/tx streams and status flags.
// slave = responder side, master = CPU/board side.
interface mem_io_responder_if;
   import mem_io_responder_pkg::*;
   logic                  rdy_in;
   logic [CPU_ADDR_W-1:0] cpu_a;
   logic                  cpu_wr;
   byte_t                 cpu_wdata;
   byte_t                 cpu_rdata;
   byte_t                 rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   byte_t                 tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_overflow;
   logic                  prog_stop;

   modport slave (
      input  rdy_in, cpu_a, cpu_wr, cpu_wdata,
      output cpu_rdata,
      input  rx_data, rx_valid,
      output rx_ready,
      output tx_data, tx_valid,
      input  tx_ready,
      output tx_overflow, prog_stop
   );

   modport master (
      output rdy_in, cpu_a, cpu_wr, cpu_wdata,
      input  cpu_rdata,
      output rx_data, rx_valid,
      input  rx_ready,
      input  tx_data, tx_valid,
      output tx_ready,
      input  tx_overflow, prog_stop
   );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO; full/empty come from registered state.
// dout reads 0x00 while empty.
module byte_fifo
   import mem_io_responder_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  i_push,
   input  byte_t i_din,
   input  logic  i_pop,
   output byte_t o_dout,
   output logic  o_full,
   output logic  o_empty
);
   localparam int L     = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 1 << L;

   byte_t        r_mem [0:DEPTH-1];
   logic [L-1:0] r_wp;
   logic [L-1:0] r_rp;
   logic [L:0]   r_cnt;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_full    = (r_cnt == (L+1)'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = o_empty ? '0 : r_mem[r_rp];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + 1'b1;
         if (w_do_pop)  r_rp <= r_rp + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_do_push) r_mem[r_wp] <= i_din;
   end
endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM plus I/O page responder with 1-cycle registered reads.
// Define MEMIO_CYCLE_CNT_EN to add the cycle counter at 0x30004..7.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int RAM_ADDR_W      = 17,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input logic              clk_in,
   input logic              rst_in,
   mem_io_responder_if.slave bus
);
   byte_t r_ram [0:(1<<RAM_ADDR_W)-1];
   byte_t r_rdata;
   logic  r_stop;
   logic  r_ovf;

   logic [RAM_ADDR_W-1:0] w_ram_a;
   logic [13:0] w_unused_hi;
   logic  w_io, w_low, w_con, w_clk_grp, w_clk_ofs;
   logic  w_rd, w_wr;
   byte_t w_rd_byte;
   logic  w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   byte_t w_rx_dout;
   logic  w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   byte_t w_tx_din, w_tx_dout;

   assign w_ram_a     = bus.cpu_a[RAM_ADDR_W-1:0];
   assign w_unused_hi = bus.cpu_a[31:18];
   assign w_io      = (bus.cpu_a[17:16] == IO_BASE);
   assign w_low     = (bus.cpu_a[15:3] == '0);
   assign w_con     = w_io && w_low
                    && (bus.cpu_a[2:0] == IO_OFS_CONSOLE);
   assign w_clk_grp = w_io && w_low
                    && (bus.cpu_a[2] == IO_OFS_CLOCK[2]);
   assign w_clk_ofs = w_io && w_low
                    && (bus.cpu_a[2:0] == IO_OFS_CLOCK);
   assign w_rd      = bus.rdy_in && !bus.cpu_wr;
   assign w_wr      = bus.rdy_in && bus.cpu_wr;

   assign w_rx_push = bus.rx_valid && !w_rx_full;
   assign w_rx_pop  = w_rd && w_con && !w_rx_empty;
   // Stop writes push a literal 0x00, bypassing the zero filter
   assign w_tx_push = w_wr && ((w_con && bus.cpu_wdata != '0)
                    || w_clk_ofs);
   assign w_tx_din  = w_clk_ofs ? '0 : bus.cpu_wdata;
   assign w_tx_pop  = !w_tx_empty && bus.tx_ready;

   byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .i_push (w_rx_push),
      .i_din  (bus.rx_data),
      .i_pop  (w_rx_pop),
      .o_dout (w_rx_dout),
      .o_full (w_rx_full),
      .o_empty(w_rx_empty)
   );

   byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .i_push (w_tx_push),
      .i_din  (w_tx_din),
      .i_pop  (w_tx_pop),
      .o_dout (w_tx_dout),
      .o_full (w_tx_full),
      .o_empty(w_tx_empty)
   );

`ifdef MEMIO_CYCLE_CNT_EN
   logic [31:0] r_cnt;
   logic [31:0] r_snap;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_cnt  <= '0;
         r_snap <= '0;
      end else begin
         if (bus.rdy_in && !r_stop) r_cnt <= r_cnt + 1'b1;
         if (w_rd && w_clk_ofs)     r_snap <= r_cnt;
      end
   end
`endif

   always_comb begin
      w_rd_byte = '0;
      if (!w_io) begin
         w_rd_byte = r_ram[w_ram_a];
      end else if (w_con) begin
         w_rd_byte = w_rx_dout;
`ifdef MEMIO_CYCLE_CNT_EN
      end else if (w_clk_grp) begin
         // Byte 0 returns the freshly latched value
         unique case (bus.cpu_a[1:0])
            2'd0:    w_rd_byte = r_cnt[7:0];
            2'd1:    w_rd_byte = r_snap[15:8];
            2'd2:    w_rd_byte = r_snap[23:16];
            default: w_rd_byte = r_snap[31:24];
         endcase
`endif
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_wr && !w_io) r_ram[w_ram_a] <= bus.cpu_wdata;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rdata <= '0;
         r_stop  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_rd)                  r_rdata <= w_rd_byte;
         if (w_wr && w_clk_ofs)     r_stop  <= 1'b1;
         if (w_tx_push && w_tx_full) r_ovf  <= 1'b1;
      end
   end

   assign bus.cpu_rdata   = r_rdata;
   assign bus.rx_ready    = !w_rx_full;
   assign bus.tx_data     = w_tx_dout;
   assign bus.tx_valid    = !w_tx_empty;
   assign bus.tx_overflow = r_ovf;
   assign bus.prog_stop   = r_stop;
endmodule
